// File: rtl/pipe_id_fwd_regfile.sv
// ID-stage register file with WB bypass, EXE/MEM operand forwarding,
// load-use stall detection and a saturating stall-cycle counter.
module pipe_id_fwd_regfile #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       rs,
  input  logic [4:0]       rt,
  input  logic             users,
  input  logic             usert,
  input  logic             ewreg,
  input  logic             em2reg,
  input  logic [4:0]       ern,
  input  logic [31:0]      ealu,
  input  logic             mwreg,
  input  logic             mm2reg,
  input  logic [4:0]       mrn,
  input  logic [31:0]      malu,
  input  logic [31:0]      mmo,
  input  logic             wwreg,
  input  logic [4:0]       wrn,
  input  logic [31:0]      wdi,
  output logic [31:0]      da,
  output logic [31:0]      db,
  output logic [1:0]       fwda,
  output logic [1:0]       fwdb,
  output logic             stall,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [31:0]      regs_q [32];
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [31:0]      rf_a, rf_b;
  logic             wb_en;
  logic             ematch_a, ematch_b, mmatch_a, mmatch_b;

  assign wb_en = wwreg && (wrn != 5'd0);

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (wb_en) begin
      regs_q[wrn] <= wdi;
    end
  end

  // WB bypass makes a same-cycle write visible to the ID read
  always_comb begin
    rf_a = regs_q[rs];
    rf_b = regs_q[rt];
    if (wb_en && (wrn == rs)) rf_a = wdi;
    if (wb_en && (wrn == rt)) rf_b = wdi;
  end

  assign ematch_a = ewreg && (ern != 5'd0) && (ern == rs);
  assign ematch_b = ewreg && (ern != 5'd0) && (ern == rt);
  assign mmatch_a = mwreg && (mrn != 5'd0) && (mrn == rs);
  assign mmatch_b = mwreg && (mrn != 5'd0) && (mrn == rt);

  // An EXE load cannot forward yet, so it falls through to the MEM match
  always_comb begin
    fwda = 2'b00;
    da   = rf_a;
    if (rs == 5'd0) begin
      da = '0;
    end else if (ematch_a && !em2reg) begin
      fwda = 2'b01;
      da   = ealu;
    end else if (mmatch_a) begin
      fwda = mm2reg ? 2'b11 : 2'b10;
      da   = mm2reg ? mmo : malu;
    end
  end

  always_comb begin
    fwdb = 2'b00;
    db   = rf_b;
    if (rt == 5'd0) begin
      db = '0;
    end else if (ematch_b && !em2reg) begin
      fwdb = 2'b01;
      db   = ealu;
    end else if (mmatch_b) begin
      fwdb = mm2reg ? 2'b11 : 2'b10;
      db   = mm2reg ? mmo : malu;
    end
  end

  assign stall = ewreg && em2reg && (ern != 5'd0) &&
                 ((users && (ern == rs)) || (usert && (ern == rt)));

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_id_fwd_regfile.sv
// Directed bench for pipe_id_fwd_regfile: vector table for forwarding/stall
// decode plus hand sequences for register writes, stall counting and reset.
module tb_pipe_id_fwd_regfile;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  rs, rt, ern, mrn, wrn;
  logic        users, usert, ewreg, em2reg, mwreg, mm2reg, wwreg;
  logic [31:0] ealu, malu, mmo, wdi;
  logic [31:0] da, db;
  logic [1:0]  fwda, fwdb;
  logic        stall;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  pipe_id_fwd_regfile #(.CNT_W(16)) dut (
    .clock(clock), .reset(reset), .rs(rs), .rt(rt), .users(users), .usert(usert),
    .ewreg(ewreg), .em2reg(em2reg), .ern(ern), .ealu(ealu),
    .mwreg(mwreg), .mm2reg(mm2reg), .mrn(mrn), .malu(malu), .mmo(mmo),
    .wwreg(wwreg), .wrn(wrn), .wdi(wdi),
    .da(da), .db(db), .fwda(fwda), .fwdb(fwdb), .stall(stall), .stall_cnt(stall_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    int unsigned rs, rt, users, usert;
    int unsigned ewreg, em2reg, ern, ealu;
    int unsigned mwreg, mm2reg, mrn, malu, mmo;
    int unsigned wwreg, wrn, wdi;
    int unsigned eda, edb, efa, efb, est;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic idle();
    rs = '0; rt = '0; users = 1'b0; usert = 1'b0;
    ewreg = 1'b0; em2reg = 1'b0; ern = '0; ealu = '0;
    mwreg = 1'b0; mm2reg = 1'b0; mrn = '0; malu = '0; mmo = '0;
    wwreg = 1'b0; wrn = '0; wdi = '0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wb_write(input logic [4:0] rn, input logic [31:0] val);
    wwreg = 1'b1; wrn = rn; wdi = val;
    tick();
    wwreg = 1'b0; wrn = '0; wdi = '0;
  endtask

  initial begin
    //        rs rt us ut  ew em ern ealu         mw mm mrn malu   mmo           ww wrn wdi          eda          edb          fa fb st
    vecs[0]  = '{5, 0, 1, 1, 0, 0, 0, 0,            0, 0, 0, 0,     0,            0, 0, 0,            'h12345678, 0,           0, 0, 0};
    vecs[1]  = '{7, 7, 1, 1, 1, 0, 7, 'hAA,         1, 0, 7, 'hBB,  0,            0, 0, 0,            'hAA,       'hAA,        1, 1, 0};
    vecs[2]  = '{5, 9, 1, 1, 0, 0, 0, 0,            1, 1, 9, 0,     'hDEADBEEF,   0, 0, 0,            'h12345678, 'hDEADBEEF,  0, 3, 0};
    vecs[3]  = '{9, 6, 1, 1, 0, 0, 0, 0,            1, 0, 9, 'h99,  0,            0, 0, 0,            'h99,       'h66,        2, 0, 0};
    vecs[4]  = '{8, 5, 1, 1, 0, 0, 0, 0,            0, 0, 0, 0,     0,            1, 8, 'h88,         'h88,       'h12345678,  0, 0, 0};
    vecs[5]  = '{0, 0, 1, 1, 0, 0, 0, 0,            1, 0, 0, 'h77,  0,            1, 0, 'hFFFFFFFF,   0,          0,           0, 0, 0};
    vecs[6]  = '{31, 31, 1, 1, 1, 0, 31, 'h00400008, 0, 0, 0, 0,    0,            1, 31, 5,           'h00400008, 'h00400008,  1, 1, 0};
    vecs[7]  = '{4, 3, 1, 1, 1, 1, 4, 'h44,         1, 0, 4, 'h55,  0,            0, 0, 0,            'h55,       0,           2, 0, 1};
    vecs[8]  = '{4, 4, 0, 0, 1, 1, 4, 'h44,         1, 0, 4, 'h55,  0,            0, 0, 0,            'h55,       'h55,        2, 2, 0};
    vecs[9]  = '{1, 4, 1, 1, 1, 1, 4, 'h44,         0, 0, 0, 0,     0,            0, 0, 0,            0,          0,           0, 0, 1};
    vecs[10] = '{5, 12, 1, 1, 1, 0, 12, 'h2222,     1, 1, 12, 0,    'h1111,       1, 5, 'hCAFE,       'hCAFE,     'h2222,      0, 1, 0};

    idle();
    reset = 1'b1;
    tick();
    tick();
    chk("rst_da", da, 32'h0);
    chk("rst_db", db, 32'h0);
    chk("rst_fwd", {28'h0, fwda, fwdb}, 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_cnt", 32'(stall_cnt), 32'h0);
    reset = 1'b0;

    wb_write(5'd5, 32'h1234_5678);
    wb_write(5'd6, 32'h0000_0066);
    wb_write(5'd0, 32'hFFFF_FFFF);
    rs = 5'd0; rt = 5'd5;
    #1;
    chk("r0_read", da, 32'h0);
    chk("r5_read", db, 32'h1234_5678);

    for (int i = 0; i < 11; i++) begin
      rs = 5'(vecs[i].rs); rt = 5'(vecs[i].rt);
      users = 1'(vecs[i].users); usert = 1'(vecs[i].usert);
      ewreg = 1'(vecs[i].ewreg); em2reg = 1'(vecs[i].em2reg);
      ern = 5'(vecs[i].ern); ealu = vecs[i].ealu;
      mwreg = 1'(vecs[i].mwreg); mm2reg = 1'(vecs[i].mm2reg);
      mrn = 5'(vecs[i].mrn); malu = vecs[i].malu; mmo = vecs[i].mmo;
      wwreg = 1'(vecs[i].wwreg); wrn = 5'(vecs[i].wrn); wdi = vecs[i].wdi;
      #1;
      chk($sformatf("v%0d_da", i), da, vecs[i].eda);
      chk($sformatf("v%0d_db", i), db, vecs[i].edb);
      chk($sformatf("v%0d_fwda", i), 32'(fwda), vecs[i].efa);
      chk($sformatf("v%0d_fwdb", i), 32'(fwdb), vecs[i].efb);
      chk($sformatf("v%0d_stall", i), 32'(stall), vecs[i].est);
      // keep the table purely combinational: no writes, no counted stalls
      idle();
      tick();
    end
    chk("cnt_after_table", 32'(stall_cnt), 32'h0);

    // load-use stall for three cycles
    ewreg = 1'b1; em2reg = 1'b1; ern = 5'd4; rs = 5'd4; users = 1'b1;
    #1;
    chk("lu_stall", 32'(stall), 32'h1);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk($sformatf("lu_cnt%0d", k), 32'(stall_cnt), 32'(k));
      chk($sformatf("lu_stall%0d", k), 32'(stall), 32'h1);
    end
    users = 1'b0; usert = 1'b0; rt = 5'd4;
    #1;
    chk("lu_nouse_stall", 32'(stall), 32'h0);
    tick();
    chk("lu_cnt_hold", 32'(stall_cnt), 32'h3);

    // saturation
    users = 1'b1;
    repeat (65537) @(posedge clock);
    #1;
    chk("sat_cnt", 32'(stall_cnt), 32'h0000_FFFF);
    tick();
    chk("sat_hold", 32'(stall_cnt), 32'h0000_FFFF);

    // reset mid-stall clears counter and regfile
    reset = 1'b1;
    tick();
    chk("rst_mid_cnt", 32'(stall_cnt), 32'h0);
    chk("rst_mid_stall", 32'(stall), 32'h1);
    reset = 1'b0;
    tick();
    chk("resume_cnt", 32'(stall_cnt), 32'h1);
    idle();
    rs = 5'd5;
    #1;
    chk("r5_cleared", da, 32'h0);
    chk("r5_cleared_fwd", 32'(fwda), 32'h0);

    // WB write during reset is discarded
    reset = 1'b1; wwreg = 1'b1; wrn = 5'd10; wdi = 32'h0000_0ABC;
    tick();
    reset = 1'b0; wwreg = 1'b0; wrn = '0; wdi = '0;
    rs = 5'd10;
    #1;
    chk("rst_wb_discard", da, 32'h0);
    tick();
    chk("rst_wb_discard2", da, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_id_fwd_regfile.md
Name: pipe_id_fwd_regfile

Overview:
- Decode-side consumer of the execute-stage result bus (ern, ealu, ewreg, em2reg) and of the MEM/WB result buses.
- Holds the 32x32 architectural register file and resolves the ID-stage source operands with full forwarding.
- Detects load-use hazards and raises a pipeline stall.
- Keeps a saturating count of stall cycles for performance debug.

Parameters:
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- rs  input  5  ID-stage source register A.
- rt  input  5  ID-stage source register B.
- users  input  1  instruction in ID actually reads rs.
- usert  input  1  instruction in ID actually reads rt.
- ewreg  input  1  EXE instruction writes a register.
- em2reg  input  1  EXE instruction is a load; its result is not yet available.
- ern  input  5  EXE destination register; 31 on jal.
- ealu  input  32  EXE result; holds pc+8 on jal.
- mwreg  input  1  MEM instruction writes a register.
- mm2reg  input  1  MEM instruction is a load.
- mrn  input  5  MEM destination register.
- malu  input  32  MEM ALU result.
- mmo  input  32  MEM load data.
- wwreg  input  1  WB write enable.
- wrn  input  5  WB destination register.
- wdi  input  32  WB write data.
- da  output  32  forwarded operand A.
- db  output  32  forwarded operand B.
- fwda  output  2  operand A source: 00 regfile/WB, 01 ealu, 10 malu, 11 mmo.
- fwdb  output  2  operand B source, same encoding as fwda.
- stall  output  1  load-use interlock; freezes PC and IF/ID.
- stall_cnt  output  CNT_W  stall cycles since reset, saturating.

Behaviour:
- Register file
  - 32 x 32-bit.
  - Write occurs on the rising clock edge when wwreg=1 and wrn!=0.
  - r0 always reads 0; writes to r0 are ignored.
- Read path is combinational with internal WB bypass: if wwreg=1, wrn!=0 and wrn==rs, the read returns wdi in the same cycle. The same rule applies to rt.
- Forwarding for operand A (operand B identical with rt/usert):
  - Condition Ematch = ewreg & ern!=0 & ern==rs.
  - Condition Mmatch = mwreg & mrn!=0 & mrn==rs.
  - Priority EXE > MEM > WB/regfile:
    - Ematch and em2reg=0 -> fwda=01, da=ealu.
    - else if Mmatch -> fwda=10 if mm2reg=0, 11 if mm2reg=1; da=malu or mmo respectively.
    - else fwda=00, da=regfile/WB-bypass value.
  - rs==0 -> fwda=00, da=0, regardless of any match.
  - The fwda/fwdb encoding is independent of users/usert; usert only gates stall.
- Stall
  - stall = ewreg & em2reg & ern!=0 & ((users & ern==rs) | (usert & ern==rt)).
  - Purely combinational, asserted in the same cycle as the hazard.
  - While stall=1, da/db may carry the stale regfile value; the consumer discards them.
  - A stalled EXE load has fwda=00 for its own match; the MEM-stage match is still applied.
- Stall counter
  - Increments by 1 at each rising edge where stall=1 and reset=0.
  - Holds at all-ones (65535 at default width); no wrap.
- Reset
  - On a clock edge with reset=1: all 32 registers cleared to 0 and stall_cnt cleared to 0.
  - A WB write in the same cycle is discarded.
  - Combinational outputs follow their inputs; with the regfile zeroed and no matches, da=db=0 and fwda=fwdb=00.
  - Reset asserted mid-stall clears the counter on that edge; the count resumes from 0 after reset deasserts.
- Simultaneous events
  - WB write and read of the same register in one cycle -> the new value is visible combinationally.
  - EXE and MEM targeting the same register -> EXE wins.
  - jal in EXE (ern=31) followed by a read of r31 -> fwd=01 with ealu (pc+8).

Test Plan:
- Reset, write r5=0x1234_5678 via WB, then rs=5 with no other matches -> da=0x12345678, fwda=00; a write to r0 of 0xFFFFFFFF -> rs=0 reads 0.
- ewreg=1, em2reg=0, ern=7, ealu=0xAA; mwreg=1, mrn=7, malu=0xBB; rs=rt=7 -> da=db=0xAA, fwda=fwdb=01, stall=0.
- mwreg=1, mm2reg=1, mrn=9, mmo=0xDEAD_BEEF, no EXE match; rt=9 -> db=0xDEADBEEF, fwdb=11.
- ewreg=1, em2reg=1, ern=4; rs=4, users=1 -> stall=1 for 3 cycles, stall_cnt 0->3; same case with users=0 and usert=0 -> stall=0.
- Force 65537 stall cycles with CNT_W=16 -> stall_cnt=0xFFFF and holds; then pulse reset for 1 cycle -> stall_cnt=0 and r5 reads 0.
- jal in EXE (ewreg=1, ern=31, ealu=0x0040_0008) and rs=31 -> da=0x00400008, fwda=01; same cycle wwreg=1, wrn=31, wdi=0x5 -> EXE still wins.
